mult8_seq_ctrl: RTL and testbench

Sequencing controller that computes an unsigned 8x8 product by time-sharing a single `Mult_4x4` array multiplier over four nibble partial products. It latches operands on a start request, feeds one nibble pair per cycle to the shared multiplier, and shift-accumulates the results into a 16-bit product. Completion is signalled with a one-cycle done pulse. It is the first clocked block built around the existing 4x4 multiplier and full-adder cells.

---
 rtl/mult8_seq_ctrl_if.sv | 20 ++
 rtl/mult8_seq_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mult8_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mult8_seq_ctrl_if.sv
// mult8_seq_ctrl_if
// Request/response bundle for the sequential 8x8 multiplier.
//   start : request a multiply (driven by master)
//   a, b  : 8-bit operands, latched by the slave on an accepted start
//   busy  : slave is stepping through partial products
//   done  : one-cycle pulse when p becomes valid
//   p     : 16-bit product, held until the next completion or reset
interface mult8_seq_ctrl_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] p;

  modport master (output start, output a, output b,
                  input  busy,  input  done, input p);
  modport slave  (input  start, input  a, input  b,
                  output busy,  output done, output p);
endinterface

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl
// Unsigned 8x8 -> 16 multiplier that time-shares one Mult_4x4 array
// multiplier over the four nibble partial products, one per cycle, and
// shift-accumulates them. A one-cycle done pulse marks a new product.
//
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset (wins over start)
//   bus : mult8_seq_ctrl_if.slave (start, a, b in; busy, done, p out)
//
// Build option:
//   MULT8_ZERO_SKIP_EN - when defined, partial-product steps whose nibble
//   pair contains a zero nibble are skipped; latency becomes
//   max(1, enabled steps). The product value is unchanged.

// Shared 4x4 unsigned array multiplier.
module Mult_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'h0, a} * {4'h0, b};
endmodule

module mult8_seq_ctrl (
  input  logic             clk,
  input  logic             rst,
  mult8_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  k_r, k_nxt_s;
  logic [3:0]  mask_r, mask_nxt_s;
  logic [7:0]  a_r, a_nxt_s;
  logic [7:0]  b_r, b_nxt_s;
  logic [15:0] acc_r, acc_nxt_s;
  logic [15:0] p_r, p_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        done_r, done_nxt_s;

  logic [3:0]  nib_a_s, nib_b_s;
  logic [7:0]  pp_s;
  logic [15:0] pp_shift_s;
  logic [15:0] add_s;
  logic [15:0] sum_s;
  logic [3:0]  accept_mask_s;
  logic        last_s;

  // Lowest enabled step; an empty mask still runs one (empty) step at k=0.
  function automatic logic [1:0] first_step(input logic [3:0] m);
    logic [1:0] r;
    if (m[0])      r = 2'd0;
    else if (m[1]) r = 2'd1;
    else if (m[2]) r = 2'd2;
    else if (m[3]) r = 2'd3;
    else           r = 2'd0;
    return r;
  endfunction

  // True when some step above k is still enabled.
  function automatic logic later_step(input logic [3:0] m, input logic [1:0] k);
    logic r;
    case (k)
      2'd0:    r = |m[3:1];
      2'd1:    r = |m[3:2];
      2'd2:    r = m[3];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Next enabled step above k; only meaningful when later_step() is true.
  function automatic logic [1:0] next_step(input logic [3:0] m, input logic [1:0] k);
    logic [1:0] r;
    case (k)
      2'd0: begin
        if (m[1])      r = 2'd1;
        else if (m[2]) r = 2'd2;
        else           r = 2'd3;
      end
      2'd1: begin
        if (m[2]) r = 2'd2;
        else      r = 2'd3;
      end
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  // Step mask computed from the incoming operands at accept time.
`ifdef MULT8_ZERO_SKIP_EN
  assign accept_mask_s = {
    (|bus.a[7:4]) & (|bus.b[7:4]),
    (|bus.a[3:0]) & (|bus.b[7:4]),
    (|bus.a[7:4]) & (|bus.b[3:0]),
    (|bus.a[3:0]) & (|bus.b[3:0])
  };
`else
  assign accept_mask_s = 4'b1111;
`endif

  // Nibble-select mux feeding the shared multiplier.
  always_comb begin
    nib_a_s = a_r[3:0];
    nib_b_s = b_r[3:0];
    case (k_r)
      2'd0:    begin nib_a_s = a_r[3:0]; nib_b_s = b_r[3:0]; end
      2'd1:    begin nib_a_s = a_r[7:4]; nib_b_s = b_r[3:0]; end
      2'd2:    begin nib_a_s = a_r[3:0]; nib_b_s = b_r[7:4]; end
      2'd3:    begin nib_a_s = a_r[7:4]; nib_b_s = b_r[7:4]; end
      default: begin nib_a_s = 4'h0;     nib_b_s = 4'h0;     end
    endcase
  end

  Mult_4x4 u_mult (
    .a (nib_a_s),
    .b (nib_b_s),
    .p (pp_s)
  );

  // Align the partial product to its nibble weight.
  always_comb begin
    pp_shift_s = 16'h0000;
    case (k_r)
      2'd0:    pp_shift_s = {8'h00, pp_s};
      2'd1:    pp_shift_s = {4'h0, pp_s, 4'h0};
      2'd2:    pp_shift_s = {4'h0, pp_s, 4'h0};
      2'd3:    pp_shift_s = {pp_s, 8'h00};
      default: pp_shift_s = 16'h0000;
    endcase
  end

  // A disabled step (only reachable with an empty mask) contributes nothing.
  assign add_s  = mask_r[k_r] ? pp_shift_s : 16'h0000;
  assign sum_s  = acc_r + add_s;
  assign last_s = ~later_step(mask_r, k_r);

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    mask_nxt_s  = mask_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    acc_nxt_s   = acc_r;
    p_nxt_s     = p_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_nxt_s     = bus.a;
          b_nxt_s     = bus.b;
          acc_nxt_s   = 16'h0000;
          mask_nxt_s  = accept_mask_s;
          k_nxt_s     = first_step(accept_mask_s);
          state_nxt_s = ST_MUL;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        // start is ignored here; operands stay as latched.
        acc_nxt_s = sum_s;
        if (last_s) begin
          p_nxt_s     = sum_s;
          state_nxt_s = ST_DONE;
        end else begin
          k_nxt_s     = next_step(mask_r, k_r);
          state_nxt_s = ST_MUL;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_MUL);
    done_nxt_s = (state_nxt_s == ST_DONE);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      k_r     <= 2'd0;
      mask_r  <= 4'h0;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      acc_r   <= 16'h0000;
      p_r     <= 16'h0000;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      mask_r  <= mask_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      acc_r   <= acc_nxt_s;
      p_r     <= p_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.p    = p_r;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// tb_mult8_seq_ctrl
// Directed self-checking bench for mult8_seq_ctrl. Expected products are
// hand-computed constants; expected latency is 4, or the count of steps
// with both nibbles nonzero (minimum 1) when MULT8_ZERO_SKIP_EN is defined.
module tb_mult8_seq_ctrl;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [15:0] last_p;

  mult8_seq_ctrl_if bus();

  mult8_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] av, input logic [7:0] bv);
    int n;
`ifdef MULT8_ZERO_SKIP_EN
    n = 0;
    if (av[3:0] != 4'h0 && bv[3:0] != 4'h0) n++;
    if (av[7:4] != 4'h0 && bv[3:0] != 4'h0) n++;
    if (av[3:0] != 4'h0 && bv[7:4] != 4'h0) n++;
    if (av[7:4] != 4'h0 && bv[7:4] != 4'h0) n++;
    if (n == 0) n = 1;
`else
    n = 4;
`endif
    return n;
  endfunction

  // Wait (bounded) for done; returns cycles waited.
  task automatic wait_done(output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 12) begin
      step();
      n++;
    end
  endtask

  // One isolated multiply: accept, check busy/hold, latency, product, pulse width.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [15:0] exp_p);
    int n;
    bus.a = av;
    bus.b = bv;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk({tag, " busy"}, bus.busy, 1'b1);
    chk({tag, " p hold"}, bus.p, last_p);
    wait_done(n);
    chk({tag, " latency"}, n, exp_lat(av, bv));
    chk({tag, " p"}, bus.p, exp_p);
    chk({tag, " busy@done"}, bus.busy, 1'b0);
    last_p = exp_p;
    step();
    chk({tag, " done pulse"}, bus.done, 1'b0);
    chk({tag, " p after"}, bus.p, exp_p);
  endtask

  initial begin
    int n;
    int extra;
    vectors     = 0;
    miscompares = 0;
    last_p      = 16'h0000;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = 8'h00;
    bus.b       = 8'h00;

    // Reset state.
    step();
    step();
    chk("rst busy", bus.busy, 1'b0);
    chk("rst done", bus.done, 1'b0);
    chk("rst p", bus.p, 16'h0000);
    rst = 1'b0;
    step();

    // Basic and mixed operands.
    run_op("2x4",   8'h02, 8'h04, 16'h0008);
    run_op("12x34", 8'h12, 8'h34, 16'h03A8);
    run_op("FFxFF", 8'hFF, 8'hFF, 16'hFE01);

    // Start while busy is ignored.
    bus.a = 8'h12; bus.b = 8'h34; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.a = 8'hFF; bus.b = 8'h01; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(n);
    chk("busy-start done seen", bus.done, 1'b1);
    chk("busy-start p", bus.p, 16'h03A8);
    last_p = 16'h03A8;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.done === 1'b1) extra++;
    end
    chk("busy-start extra done", extra, 0);
    chk("busy-start p hold", bus.p, 16'h03A8);

    // Back-to-back: start held through the DONE cycle.
    bus.a = 8'h0F; bus.b = 8'h0F; bus.start = 1'b1;
    step();
    wait_done(n);
    chk("b2b first latency", n, exp_lat(8'h0F, 8'h0F));
    chk("b2b first p", bus.p, 16'h00E1);
    step();
    bus.start = 1'b0;
    chk("b2b reaccept busy", bus.busy, 1'b1);
    chk("b2b reaccept done", bus.done, 1'b0);
    wait_done(n);
    chk("b2b second latency", n, exp_lat(8'h0F, 8'h0F));
    chk("b2b second p", bus.p, 16'h00E1);
    last_p = 16'h00E1;
    step();

    // Reset in the middle of an operation.
    bus.a = 8'hFF; bus.b = 8'hFF; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst busy", bus.busy, 1'b0);
    chk("midrst done", bus.done, 1'b0);
    chk("midrst p", bus.p, 16'h0000);
    last_p = 16'h0000;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done === 1'b1) extra++;
    end
    chk("midrst no done", extra, 0);
    run_op("3x5", 8'h03, 8'h05, 16'h000F);

    // Zero-nibble operands (skipped steps when the option is built in).
    run_op("0Fx03", 8'h0F, 8'h03, 16'h002D);
    run_op("00x55", 8'h00, 8'h55, 16'h0000);
    run_op("F0x11", 8'hF0, 8'h11, 16'h0FF0);

    // rst and start together: rst wins.
    bus.a = 8'h07; bus.b = 8'h07; bus.start = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; bus.start = 1'b0;
    chk("rst+start busy", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
